// File: rtl/i2s_tx.sv
// ============================================================================
// Module   : i2s_tx
// Brief    : Stereo I2S transmitter; divides clock into BCLK/LRCK and shifts out
//            the latched {L16, R16} frame. Define I2S_TX_LJ_EN for left-justified.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx #(
   parameter int DIV = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [14:0] left,
   input  logic [14:0] right,
   output logic        strobe,
   output logic        bclk,
   output logic        lrck,
   output logic        sdata
);

   localparam logic [7:0] C_CNT_MAX = 8'(DIV - 1);

   logic [7:0]  cnt_q, cnt_d;
   logic        bclk_q, bclk_d;
   logic [4:0]  pos_q, pos_d;
   logic        lrck_q, lrck_d;
   logic        sdata_q, sdata_d;
   logic        strobe_q, strobe_d;
   logic [31:0] frame_q, frame_d;
   logic [31:0] w_capture;
   logic [4:0]  w_idx;

   // Unsigned 15-bit mixer value to 16-bit two's complement (offset-binary flip).
   function automatic logic [15:0] to_pcm(input logic [14:0] x);
      return {~x[14], x[13:0], 1'b0};
   endfunction

   assign w_capture = {to_pcm(left), to_pcm(right)};

   always_comb begin
      cnt_d    = cnt_q;
      bclk_d   = bclk_q;
      pos_d    = pos_q;
      lrck_d   = lrck_q;
      sdata_d  = sdata_q;
      strobe_d = 1'b0;
      frame_d  = frame_q;
      w_idx    = 5'd0;
      if (cnt_q == C_CNT_MAX) begin
         cnt_d  = 8'd0;
         bclk_d = ~bclk_q;
         if (bclk_q) begin
            pos_d  = pos_q + 5'd1;
            lrck_d = pos_d[4];
`ifdef I2S_TX_LJ_EN
            w_idx   = ~pos_d;
            sdata_d = (pos_d == 5'd0) ? w_capture[31] : frame_q[w_idx];
`else
            // At pos 0 the index wraps to bit 0 of the outgoing frame (prev R LSB).
            w_idx   = ~(pos_d - 5'd1);
            sdata_d = frame_q[w_idx];
`endif
            if (pos_d == 5'd0) begin
               frame_d  = w_capture;
               strobe_d = 1'b1;
            end
         end
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q    <= 8'd0;
         bclk_q   <= 1'b0;
         pos_q    <= 5'd31;
         lrck_q   <= 1'b0;
         sdata_q  <= 1'b0;
         strobe_q <= 1'b0;
         frame_q  <= 32'd0;
      end else begin
         cnt_q    <= cnt_d;
         bclk_q   <= bclk_d;
         pos_q    <= pos_d;
         lrck_q   <= lrck_d;
         sdata_q  <= sdata_d;
         strobe_q <= strobe_d;
         frame_q  <= frame_d;
      end
   end

   assign strobe = strobe_q;
   assign bclk   = bclk_q;
   assign lrck   = lrck_q;
   assign sdata  = sdata_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ============================================================================
// Module   : tb_i2s_tx
// Brief    : Directed bench for i2s_tx with DIV=2 and DIV=1 instances; decodes
//            the serial stream per BCLK falling tick and compares to fixed words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx;

   logic        clock = 1'b0;
   logic        reset;
   logic [14:0] left, right;
   logic        strobe2, bclk2, lrck2, sdata2;
   logic        strobe1, bclk1, lrck1, sdata1;
   logic        w_strobe, w_bclk, w_lrck, w_sdata;
   int          sel_div;
   int          checks   = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   i2s_tx #(.DIV(2)) u_dut2 (
      .clock(clock), .reset(reset), .left(left), .right(right),
      .strobe(strobe2), .bclk(bclk2), .lrck(lrck2), .sdata(sdata2)
   );

   i2s_tx #(.DIV(1)) u_dut1 (
      .clock(clock), .reset(reset), .left(left), .right(right),
      .strobe(strobe1), .bclk(bclk1), .lrck(lrck1), .sdata(sdata1)
   );

   assign w_strobe = (sel_div == 1) ? strobe1 : strobe2;
   assign w_bclk   = (sel_div == 1) ? bclk1   : bclk2;
   assign w_lrck   = (sel_div == 1) ? lrck1   : lrck2;
   assign w_sdata  = (sel_div == 1) ? sdata1  : sdata2;

   typedef struct {
      logic [14:0] l_in;
      logic [14:0] r_in;
      logic [15:0] l_exp;
      logic [15:0] r_exp;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (w_strobe) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_fall(output bit ok);
      logic prevb;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         prevb = w_bclk;
         @(negedge clock);
         if (prevb && !w_bclk) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called on the sample where strobe is high (pos 0); returns on the next strobe.
   task automatic get_frame(input int chg_pos, input logic [14:0] chg_left,
                            output logic [15:0] l, output logic [15:0] r,
                            output bit lrck_bad, output bit strobe_bad,
                            output int spacing, output bit ok);
      logic s[0:32];
      logic prevb;
      bit   f;
      int   n;
      s[0]       = w_sdata;
      lrck_bad   = (w_lrck !== 1'b0);
      strobe_bad = 1'b0;
      spacing    = 0;
      ok         = 1'b1;
      for (int p = 1; p <= 32; p++) begin
         f = 1'b0;
         n = 0;
         while (!f && n < 600) begin
            prevb = w_bclk;
            @(negedge clock);
            n++;
            spacing++;
            if (prevb && !w_bclk) f = 1'b1;
            else if (w_strobe) strobe_bad = 1'b1;
         end
         if (!f) ok = 1'b0;
         s[p] = w_sdata;
         if (w_lrck !== ((p % 32) >= 16)) lrck_bad = 1'b1;
         if (w_strobe !== (p == 32)) strobe_bad = 1'b1;
         if (p == chg_pos) left = chg_left;
      end
      for (int b = 0; b < 16; b++) begin
`ifdef I2S_TX_LJ_EN
         l[15-b] = s[b];
         r[15-b] = s[16+b];
`else
         l[15-b] = s[1+b];
         r[15-b] = s[17+b];
`endif
      end
   endtask

   task automatic frame_checks(input string tag, input logic [15:0] l_exp, input logic [15:0] r_exp,
                               input int chg_pos, input logic [14:0] chg_left, input int spc_exp);
      logic [15:0] l, r;
      bit lb, sb, ok;
      int spc;
      get_frame(chg_pos, chg_left, l, r, lb, sb, spc, ok);
      check({tag, "_ticks"}, 32'(ok), 32'd1);
      check({tag, "_L"}, 32'(l), 32'(l_exp));
      check({tag, "_R"}, 32'(r), 32'(r_exp));
      check({tag, "_lrck"}, 32'(lb), 32'd0);
      check({tag, "_strobe_only_pos0"}, 32'(sb), 32'd0);
      check({tag, "_spacing"}, 32'(spc), 32'(spc_exp));
   endtask

   initial begin
      logic       exp_bclk[5];
      logic       exp_strb[5];
      bit         ok;
      int         n;
      bit         toggles;
      logic       pb;

      vecs[0] = '{15'h7FFF, 15'h0000, 16'h7FFE, 16'h8000};
      vecs[1] = '{15'h4000, 15'h7FFF, 16'h0000, 16'h7FFE};
      vecs[2] = '{15'h1234, 15'h5555, 16'hA468, 16'h2AAA};
      vecs[3] = '{15'h0001, 15'h7FFE, 16'h8002, 16'h7FFC};
      exp_bclk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_strb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      sel_div = 2;
      reset   = 1'b0;
      left    = 15'h0;
      right   = 15'h0;

      // Reset hold and release timing
      repeat (10) @(negedge clock);
      check("reset_outs_div2", {28'd0, strobe2, bclk2, lrck2, sdata2}, 32'd0);
      check("reset_outs_div1", {28'd0, strobe1, bclk1, lrck1, sdata1}, 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check($sformatf("rel_clk%0d_bclk", k + 1), 32'(bclk2), 32'(exp_bclk[k]));
         check($sformatf("rel_clk%0d_strobe", k + 1), 32'(strobe2), 32'(exp_strb[k]));
         check($sformatf("rel_clk%0d_lrck", k + 1), 32'(lrck2), 32'd0);
      end

      // Table-driven frame content, DIV=2
      for (int v = 0; v < 4; v++) begin
         left  = vecs[v].l_in;
         right = vecs[v].r_in;
         wait_strobe(ok);
         check($sformatf("vec%0d_strobe_seen", v), 32'(ok), 32'd1);
         frame_checks($sformatf("vec%0d", v), vecs[v].l_exp, vecs[v].r_exp, -1, 15'h0, 128);
      end

      // Capture isolation: change left mid-frame
      left  = 15'h4000;
      right = 15'h0000;
      wait_strobe(ok);
      check("iso_strobe_seen", 32'(ok), 32'd1);
      frame_checks("iso_cur", 16'h0000, 16'h8000, 5, 15'h7FFF, 128);
      frame_checks("iso_next", 16'h7FFE, 16'h8000, -1, 15'h0, 128);

      // Reset mid-frame at pos 20
      wait_strobe(ok);
      for (int i = 0; i < 20; i++) wait_fall(ok);
      check("mid_pos20_reached", 32'(ok), 32'd1);
      check("mid_lrck_at_pos20", 32'(lrck2), 32'd1);
      reset = 1'b0;
      @(negedge clock);
      check("mid_reset_outs", {28'd0, strobe2, bclk2, lrck2, sdata2}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         n++;
         if (strobe2) begin
            ok = 1'b1;
            break;
         end
      end
      check("mid_first_strobe_clk", 32'(n), 32'd4);
      check("mid_sdata_pos0", 32'(sdata2), 32'd0);

      // DIV=1
      sel_div = 1;
      left    = 15'h0001;
      right   = 15'h7FFE;
      toggles = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pb = bclk1;
         @(negedge clock);
         if (bclk1 === pb) toggles = 1'b0;
      end
      check("div1_bclk_toggles", 32'(toggles), 32'd1);
      wait_strobe(ok);
      check("div1_strobe_seen", 32'(ok), 32'd1);
      frame_checks("div1_a", 16'h8002, 16'h7FFC, -1, 15'h0, 64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
